// File: rtl/vga_mem_pkg.sv
// Shared types, default sizes and the lane range check for the VGA frame-buffer memory.
package vga_mem_pkg;

  localparam int DEF_DATA_BYTES = 4;
  localparam int DEF_DEPTH      = 38400;

  typedef enum logic {
    IDLE,
    PENDING
  } swap_state_t;

  // Byte lane `lane` of an access at `addr` lands inside the bank (no wrap-around).
  function automatic logic in_range(input int unsigned addr, input int unsigned lane,
                                    input int unsigned depth = DEF_DEPTH);
    return (addr + lane) < depth;
  endfunction

endpackage

// File: rtl/vga_frame_mem_if.sv
// Writer, scan-out reader and bank-swap handshake signals of the frame-buffer memory.
interface vga_frame_mem_if
  import vga_mem_pkg::*;
#(
  parameter int DATA_BYTES = DEF_DATA_BYTES,
  parameter int ADDR_W     = 16
);
  logic                    wren;
  logic [ADDR_W-1:0]       wraddress;
  logic [8*DATA_BYTES-1:0] data;
  logic [DATA_BYTES-1:0]   byteen;
  logic                    rden;
  logic [ADDR_W-1:0]       rdaddress;
  logic [8*DATA_BYTES-1:0] q;
  logic                    rd_valid;
  logic                    rd_oob;
  logic                    frame_start;
  logic                    swap_req;
  logic                    swap_pending;
  logic                    swap_done;
  logic                    front_bank;

  modport master (
    output wren, wraddress, data, byteen, rden, rdaddress, frame_start, swap_req,
    input  q, rd_valid, rd_oob, swap_pending, swap_done, front_bank
  );

  modport slave (
    input  wren, wraddress, data, byteen, rden, rdaddress, frame_start, swap_req,
    output q, rd_valid, rd_oob, swap_pending, swap_done, front_bank
  );
endinterface

// File: rtl/vga_mem_bank.sv
// One frame-buffer bank: byte array with per-lane write enables and a combinational lane read.
module vga_mem_bank
  import vga_mem_pkg::*;
#(
  parameter int DATA_BYTES = DEF_DATA_BYTES,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_W     = 16
) (
  input  logic                    clk,
  input  logic [DATA_BYTES-1:0]   we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [8*DATA_BYTES-1:0] wdata,
  input  logic [ADDR_W-1:0]       raddr,
  output logic [8*DATA_BYTES-1:0] rdata
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]            mem [DEPTH];
  logic [DATA_BYTES-1:0] wr_ok;
  logic [IDX_W-1:0]      widx [DATA_BYTES];
  logic [IDX_W-1:0]      ridx [DATA_BYTES];

  // Index truncation is safe: lanes are only used once the range check has passed.
  for (genvar i = 0; i < DATA_BYTES; i++) begin : g_lane
    assign widx[i]         = IDX_W'(32'(waddr) + i);
    assign ridx[i]         = IDX_W'(32'(raddr) + i);
    assign wr_ok[i]        = we[i] && in_range(32'(waddr), i, DEPTH);
    assign rdata[8*i +: 8] = in_range(32'(raddr), i, DEPTH) ? mem[ridx[i]] : 8'h00;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (wr_ok[i]) mem[widx[i]] <= wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/vga_frame_mem.sv
// Byte-addressed dual-port frame buffer with pipelined scan-out reads and optional
// frame-synchronised double buffering.
module vga_frame_mem
  import vga_mem_pkg::*;
#(
  parameter int DATA_BYTES = DEF_DATA_BYTES,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_W     = 16,
  parameter int READ_LAT   = 1,
  parameter int DOUBLE_BUF = 1,
  parameter int RDW_NEW    = 0
) (
  input logic            clock,
  input logic            reset,
  vga_frame_mem_if.slave bus
);
  localparam int NBANKS = DOUBLE_BUF + 1;
  localparam int DW     = 8 * DATA_BYTES;

  swap_state_t           state_q, state_d;
  logic                  front_q, front_d;
  logic                  done_q, done_d;
  logic                  wr_bank;
  logic [DW-1:0]         bank_rdata [NBANKS];
  logic [DW-1:0]         rd_word;
  logic [DATA_BYTES-1:0] rd_lane_ok;
  logic                  rd_oob_c;

  // Scan-out always reads the front bank; the writer owns the other one.
  assign wr_bank = (DOUBLE_BUF != 0) ? ~front_q : 1'b0;

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    vga_mem_bank #(
      .DATA_BYTES(DATA_BYTES),
      .DEPTH     (DEPTH),
      .ADDR_W    (ADDR_W)
    ) u_bank (
      .clk  (clock),
      .we   ((bus.wren && (wr_bank == 1'(b))) ? bus.byteen : '0),
      .waddr(bus.wraddress),
      .wdata(bus.data),
      .raddr(bus.rdaddress),
      .rdata(bank_rdata[b])
    );
  end

  for (genvar i = 0; i < DATA_BYTES; i++) begin : g_rlane
    assign rd_lane_ok[i] = in_range(32'(bus.rdaddress), i, DEPTH);
  end
  assign rd_oob_c = ~&rd_lane_ok;

  // Forwarding can only hit with a single bank; any write lane may alias any read lane.
  always_comb begin
    rd_word = (DOUBLE_BUF != 0 && front_q) ? bank_rdata[NBANKS-1] : bank_rdata[0];
    if (RDW_NEW != 0 && DOUBLE_BUF == 0 && bus.wren) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        for (int j = 0; j < DATA_BYTES; j++) begin
          if (bus.byteen[j] && in_range(32'(bus.wraddress), j, DEPTH) &&
              (32'(bus.wraddress) + 32'(j) == 32'(bus.rdaddress) + 32'(i)))
            rd_word[8*i +: 8] = bus.data[8*j +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      front_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      front_q <= front_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    front_d = front_q;
    done_d  = 1'b0;
    if (DOUBLE_BUF != 0) begin
      if (bus.frame_start && (state_q == PENDING || bus.swap_req)) begin
        state_d = IDLE;
        front_d = ~front_q;
        done_d  = 1'b1;
      end else if (bus.swap_req) begin
        state_d = PENDING;
      end
    end
  end

  assign bus.swap_pending = (state_q == PENDING);
  assign bus.swap_done    = done_q;
  assign bus.front_bank   = front_q;

  // Stage p0: bank read captured; q only moves on a real request.
  logic          vld_p0, oob_p0;
  logic [DW-1:0] q_p0;

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      oob_p0 <= 1'b0;
      q_p0   <= '0;
    end else begin
      vld_p0 <= bus.rden;
      oob_p0 <= bus.rden & rd_oob_c;
      if (bus.rden) q_p0 <= rd_word;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    // Stage p1: extra output register for the two-cycle latency option.
    logic          vld_p1, oob_p1;
    logic [DW-1:0] q_p1;

    always_ff @(posedge clock) begin
      if (reset) begin
        vld_p1 <= 1'b0;
        oob_p1 <= 1'b0;
        q_p1   <= '0;
      end else begin
        vld_p1 <= vld_p0;
        oob_p1 <= oob_p0;
        if (vld_p0) q_p1 <= q_p0;
      end
    end

    assign bus.q        = q_p1;
    assign bus.rd_valid = vld_p1;
    assign bus.rd_oob   = oob_p1;
  end else begin : g_lat1
    assign bus.q        = q_p0;
    assign bus.rd_valid = vld_p0;
    assign bus.rd_oob   = oob_p0;
  end

endmodule

// File: tb/tb_vga_frame_mem.sv
// Bench for vga_frame_mem: three configurations driven in lockstep against a byte-array model.
module tb_vga_frame_mem;

  localparam int NI = 3;
  localparam int DEP [NI] = '{38400, 64, 64};
  localparam int LAT [NI] = '{1, 2, 1};
  localparam bit DBF [NI] = '{1'b1, 1'b0, 1'b0};
  localparam bit RN  [NI] = '{1'b0, 1'b1, 1'b0};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        wren, rden, fs, sr;
  logic [15:0] wa, ra;
  logic [31:0] wd;
  logic [3:0]  be;

  vga_frame_mem_if #(.DATA_BYTES(4), .ADDR_W(16)) if0 ();
  vga_frame_mem_if #(.DATA_BYTES(4), .ADDR_W(16)) if1 ();
  vga_frame_mem_if #(.DATA_BYTES(4), .ADDR_W(16)) if2 ();

  assign if0.wren = wren; assign if0.wraddress = wa; assign if0.data = wd; assign if0.byteen = be;
  assign if0.rden = rden; assign if0.rdaddress = ra; assign if0.frame_start = fs; assign if0.swap_req = sr;
  assign if1.wren = wren; assign if1.wraddress = wa; assign if1.data = wd; assign if1.byteen = be;
  assign if1.rden = rden; assign if1.rdaddress = ra; assign if1.frame_start = fs; assign if1.swap_req = sr;
  assign if2.wren = wren; assign if2.wraddress = wa; assign if2.data = wd; assign if2.byteen = be;
  assign if2.rden = rden; assign if2.rdaddress = ra; assign if2.frame_start = fs; assign if2.swap_req = sr;

  logic [31:0] q_o [NI];
  logic        v_o [NI], oob_o [NI], fb_o [NI], sp_o [NI], sd_o [NI];
  assign q_o[0] = if0.q; assign v_o[0] = if0.rd_valid; assign oob_o[0] = if0.rd_oob;
  assign fb_o[0] = if0.front_bank; assign sp_o[0] = if0.swap_pending; assign sd_o[0] = if0.swap_done;
  assign q_o[1] = if1.q; assign v_o[1] = if1.rd_valid; assign oob_o[1] = if1.rd_oob;
  assign fb_o[1] = if1.front_bank; assign sp_o[1] = if1.swap_pending; assign sd_o[1] = if1.swap_done;
  assign q_o[2] = if2.q; assign v_o[2] = if2.rd_valid; assign oob_o[2] = if2.rd_oob;
  assign fb_o[2] = if2.front_bank; assign sp_o[2] = if2.swap_pending; assign sd_o[2] = if2.swap_done;

  vga_frame_mem u0 (.clock(clock), .reset(reset), .bus(if0));
  vga_frame_mem #(.DEPTH(64), .READ_LAT(2), .DOUBLE_BUF(0), .RDW_NEW(1))
    u1 (.clock(clock), .reset(reset), .bus(if1));
  vga_frame_mem #(.DEPTH(64), .READ_LAT(1), .DOUBLE_BUF(0), .RDW_NEW(0))
    u2 (.clock(clock), .reset(reset), .bus(if2));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model state: byte contents plus a written flag so never-written bytes are not compared.
  logic [7:0]  mm [NI][2][38400];
  bit          kn [NI][2][38400];
  bit          mfront [NI], mpend [NI], mdone [NI];
  bit          ev [NI][4];
  logic [31:0] ed [NI][4], em [NI][4];
  bit          eo [NI][4];
  logic [31:0] lq [NI], lm [NI];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp,
                     input logic [31:0] msk);
    checks++;
    if (((act ^ exp) & msk) != 32'h0) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h mask=%h", nm, cyc, act, exp, msk);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    logic [31:0] d, m;
    bit o;
    int a, rb, wb, s;
    for (int k = 0; k < NI; k++) begin
      d = '0; m = '0; o = 1'b0;
      rb = int'(mfront[k]);
      wb = DBF[k] ? int'(!mfront[k]) : 0;
      for (int i = 0; i < 4; i++) begin
        a = int'(ra) + i;
        if (a >= DEP[k]) begin
          o = 1'b1;
          m[8*i +: 8] = 8'hFF;
        end else begin
          if (kn[k][rb][a]) begin
            d[8*i +: 8] = mm[k][rb][a];
            m[8*i +: 8] = 8'hFF;
          end
          if (RN[k] && !DBF[k] && wren) begin
            for (int j = 0; j < 4; j++) begin
              if (be[j] && (int'(wa) + j == a)) begin
                d[8*i +: 8] = wd[8*j +: 8];
                m[8*i +: 8] = 8'hFF;
              end
            end
          end
        end
      end
      if (wren) begin
        for (int j = 0; j < 4; j++) begin
          a = int'(wa) + j;
          if (be[j] && a < DEP[k]) begin
            mm[k][wb][a] = wd[8*j +: 8];
            kn[k][wb][a] = 1'b1;
          end
        end
      end
      s = (cyc + LAT[k]) % 4;
      mdone[k] = 1'b0;
      if (reset) begin
        mfront[k] = 1'b0;
        mpend[k]  = 1'b0;
        for (int t = 0; t < 4; t++) ev[k][t] = 1'b0;
        lq[k] = '0;
        lm[k] = '1;
      end else begin
        if (rden) begin
          ev[k][s] = 1'b1; ed[k][s] = d; em[k][s] = m; eo[k][s] = o;
        end
        if (DBF[k]) begin
          if (fs && (mpend[k] || sr)) begin
            mfront[k] = !mfront[k];
            mpend[k]  = 1'b0;
            mdone[k]  = 1'b1;
          end else if (sr) begin
            mpend[k] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check_out();
    int s;
    s = cyc % 4;
    for (int k = 0; k < NI; k++) begin
      if (ev[k][s]) begin
        chk1($sformatf("u%0d.rd_valid", k), v_o[k], 1'b1);
        chk($sformatf("u%0d.q", k), q_o[k], ed[k][s], em[k][s]);
        chk1($sformatf("u%0d.rd_oob", k), oob_o[k], eo[k][s]);
        lq[k] = ed[k][s];
        lm[k] = em[k][s];
        ev[k][s] = 1'b0;
      end else begin
        chk1($sformatf("u%0d.rd_valid", k), v_o[k], 1'b0);
        chk($sformatf("u%0d.q_hold", k), q_o[k], lq[k], lm[k]);
        chk1($sformatf("u%0d.rd_oob", k), oob_o[k], 1'b0);
      end
      chk1($sformatf("u%0d.front_bank", k), fb_o[k], mfront[k]);
      chk1($sformatf("u%0d.swap_pending", k), sp_o[k], mpend[k]);
      chk1($sformatf("u%0d.swap_done", k), sd_o[k], mdone[k]);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    cyc++;
    #1;
    check_out();
  endtask

  task automatic drive(input bit w, input logic [15:0] a, input logic [31:0] d, input logic [3:0] b,
                       input bit r, input logic [15:0] radr, input bit f, input bit s);
    wren = w; wa = a; wd = d; be = b; rden = r; ra = radr; fs = f; sr = s;
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] wa;
    logic [31:0] wd;
    logic [3:0]  be;
    bit          rd;
    logic [15:0] ra;
    bit          fs;
    bit          sr;
    bit          ev;
    logic [31:0] eq;
    bit          eoob;
    bit          efront;
    bit          epend;
    bit          edone;
  } vec_t;

  vec_t tbl [16];
  bit   fprev;

  initial begin
    // Directed vectors for the default configuration (double-buffered, latency 1, old-data RDW).
    tbl[0]  = '{1, 16'd9,     32'h00000000, 4'b0001, 0, 16'd0,     0, 0, 0, 32'h0,        0, 0, 0, 0};
    tbl[1]  = '{1, 16'd5,     32'hDDCCBBAA, 4'b1111, 0, 16'd0,     0, 0, 0, 32'h0,        0, 0, 0, 0};
    tbl[2]  = '{0, 16'd0,     32'h0,        4'b0000, 0, 16'd0,     0, 1, 0, 32'h0,        0, 0, 1, 0};
    tbl[3]  = '{0, 16'd0,     32'h0,        4'b0000, 0, 16'd0,     1, 0, 0, 32'h0,        0, 1, 0, 1};
    tbl[4]  = '{0, 16'd0,     32'h0,        4'b0000, 1, 16'd5,     0, 0, 1, 32'hDDCCBBAA, 0, 1, 0, 0};
    tbl[5]  = '{0, 16'd0,     32'h0,        4'b0000, 1, 16'd6,     0, 0, 1, 32'h00DDCCBB, 0, 1, 0, 0};
    tbl[6]  = '{1, 16'd0,     32'h11223344, 4'b1111, 0, 16'd0,     0, 0, 0, 32'h0,        0, 1, 0, 0};
    tbl[7]  = '{0, 16'd0,     32'h0,        4'b0000, 0, 16'd0,     1, 1, 0, 32'h0,        0, 0, 0, 1};
    tbl[8]  = '{0, 16'd0,     32'h0,        4'b0000, 0, 16'd0,     1, 1, 0, 32'h0,        0, 1, 0, 1};
    tbl[9]  = '{1, 16'd0,     32'hFFFFFFFF, 4'b0101, 0, 16'd0,     0, 0, 0, 32'h0,        0, 1, 0, 0};
    tbl[10] = '{0, 16'd0,     32'h0,        4'b0000, 0, 16'd0,     1, 1, 0, 32'h0,        0, 0, 0, 1};
    tbl[11] = '{0, 16'd0,     32'h0,        4'b0000, 1, 16'd0,     0, 0, 1, 32'h11FF33FF, 0, 0, 0, 0};
    tbl[12] = '{1, 16'd38398, 32'h44332211, 4'b1111, 0, 16'd0,     0, 0, 0, 32'h0,        0, 0, 0, 0};
    tbl[13] = '{0, 16'd0,     32'h0,        4'b0000, 0, 16'd0,     1, 1, 0, 32'h0,        0, 1, 0, 1};
    tbl[14] = '{0, 16'd0,     32'h0,        4'b0000, 1, 16'd38398, 1, 1, 1, 32'h00002211, 1, 0, 0, 1};
    tbl[15] = '{0, 16'd0,     32'h0,        4'b0000, 1, 16'd0,     0, 0, 1, 32'h11FF33FF, 0, 0, 0, 0};

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].wr, tbl[i].wa, tbl[i].wd, tbl[i].be, tbl[i].rd, tbl[i].ra, tbl[i].fs, tbl[i].sr);
      step();
      chk1($sformatf("vec%0d.rd_valid", i), v_o[0], tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("vec%0d.q", i), q_o[0], tbl[i].eq, 32'hFFFFFFFF);
      chk1($sformatf("vec%0d.rd_oob", i), oob_o[0], tbl[i].eoob);
      chk1($sformatf("vec%0d.front_bank", i), fb_o[0], tbl[i].efront);
      chk1($sformatf("vec%0d.swap_pending", i), sp_o[0], tbl[i].epend);
      chk1($sformatf("vec%0d.swap_done", i), sd_o[0], tbl[i].edone);
    end

    // Swap request held across ten idle cycles, then honoured on the frame boundary.
    fprev = fb_o[0];
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk1("hs.pending_wait", sp_o[0], 1'b1);
      chk1("hs.done_wait", sd_o[0], 1'b0);
      chk1("hs.front_wait", fb_o[0], fprev);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    step();
    chk1("hs.done", sd_o[0], 1'b1);
    chk1("hs.front_toggle", fb_o[0], !fprev);
    chk1("hs.pending_clear", sp_o[0], 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk1("hs.done_once", sd_o[0], 1'b0);
    chk1("hs.front_stable", fb_o[0], !fprev);

    // Two requests before a single frame boundary give a single toggle.
    fprev = fb_o[0];
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    step();
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    step();
    chk1("hs2.front_toggle", fb_o[0], !fprev);
    chk1("hs2.done", sd_o[0], 1'b1);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    step();
    chk1("hs2.no_second_toggle", fb_o[0], !fprev);
    chk1("hs2.no_second_done", sd_o[0], 1'b0);

    // Same-cycle read and write of address 8 on the single-bank configurations.
    drive(1, 16'd8, 32'hA5A5A5A5, 4'b1111, 0, 0, 0, 0);
    step();
    drive(1, 16'd8, 32'h5A5A5A5A, 4'b1111, 1, 16'd8, 0, 0);
    step();
    chk1("rdw.lat1_valid", v_o[2], 1'b1);
    chk("rdw.lat1_old", q_o[2], 32'hA5A5A5A5, 32'hFFFFFFFF);
    chk1("rdw.lat2_not_yet", v_o[1], 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk1("rdw.lat2_valid", v_o[1], 1'b1);
    chk("rdw.lat2_new", q_o[1], 32'h5A5A5A5A, 32'hFFFFFFFF);
    chk1("rdw.lat1_single", v_o[2], 1'b0);

    // Reset in the middle of back-to-back reads flushes in-flight requests only.
    drive(0, 0, 0, 0, 1, 16'd0, 0, 0);
    step();
    reset = 1'b1;
    step();
    chk1("rst.u0_valid", v_o[0], 1'b0);
    chk1("rst.u1_valid", v_o[1], 1'b0);
    chk("rst.u0_q", q_o[0], 32'h0, 32'hFFFFFFFF);
    chk1("rst.front", fb_o[0], 1'b0);
    reset = 1'b0;
    step();
    chk1("rst.u1_flushed", v_o[1], 1'b0);
    chk("rst.u0_mem_intact", q_o[0], 32'h11FF33FF, 32'hFFFFFFFF);
    chk("rst.u2_mem_intact", q_o[2], 32'h11FF33FF, 32'hFFFFFFFF);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk1("rst.u1_valid_after", v_o[1], 1'b1);
    chk("rst.u1_mem_intact", q_o[1], 32'h11FF33FF, 32'hFFFFFFFF);

    // Randomised traffic against the model; addresses straddle the small-bank edge.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      wren  = 1'($urandom_range(0, 1));
      wa    = 16'($urandom_range(0, 72));
      wd    = $urandom;
      be    = 4'($urandom_range(0, 15));
      rden  = 1'($urandom_range(0, 1));
      ra    = 16'($urandom_range(0, 72));
      fs    = ($urandom_range(0, 7) == 0);
      sr    = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
